// File: rtl/matrix_mul_pkg.sv
// matrix_mul_pkg: shared state encoding and 8-step schedule for the 2x2 block multiplier
package matrix_mul_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;
   localparam int STEPS = 8;
   // element index 0..3 = x11, x12, x21, x22; entry k sits at slice [k]
   localparam logic [7:0][1:0] A_SCHED   = {2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd0};
   localparam logic [7:0][1:0] B_SCHED   = {2'd3, 2'd1, 2'd2, 2'd0, 2'd3, 2'd1, 2'd2, 2'd0};
   localparam logic [7:0][1:0] ACC_SCHED = {2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0};
endpackage

// File: rtl/serial_mult_acc.sv
// serial_mult_acc: unsigned multiply-accumulate truncated to data_w with overflow detect
module serial_mult_acc #(
   parameter int data_w = 8
) (
   input  logic [data_w-1:0] a_i,
   input  logic [data_w-1:0] b_i,
   input  logic [data_w-1:0] acc_i,
   output logic [data_w-1:0] sum_o,
   output logic              ovf_o
);
   logic [2*data_w-1:0] prod;
   logic [data_w:0]     sum;
   assign prod  = {{data_w{1'b0}}, a_i} * {{data_w{1'b0}}, b_i};
   assign sum   = {1'b0, acc_i} + {1'b0, prod[data_w-1:0]};
   assign sum_o = sum[data_w-1:0];
   // a sum carry out or any high product bit means the true value left data_w bits
   assign ovf_o = (|prod[2*data_w-1:data_w]) | sum[data_w];
endmodule

// File: rtl/block_mac_2x2.sv
// block_mac_2x2: serial 2x2 block multiplier C = A*B using one shared multiplier over 8 cycles
module block_mac_2x2
   import matrix_mul_pkg::*;
#(
   parameter int data_w = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_mac,
   input  logic [data_w-1:0] a_11,
   input  logic [data_w-1:0] a_12,
   input  logic [data_w-1:0] a_21,
   input  logic [data_w-1:0] a_22,
   input  logic [data_w-1:0] b_11,
   input  logic [data_w-1:0] b_12,
   input  logic [data_w-1:0] b_21,
   input  logic [data_w-1:0] b_22,
   output logic [data_w-1:0] c_11,
   output logic [data_w-1:0] c_12,
   output logic [data_w-1:0] c_21,
   output logic [data_w-1:0] c_22,
   output logic              done_mac,
   output logic              busy,
   output logic              ovf
);
   state_t            state_q;
   logic [2:0]        k_q;
   logic [data_w-1:0] a_q [4];
   logic [data_w-1:0] b_q [4];
   logic [data_w-1:0] acc_q [4];
   logic [data_w-1:0] c_q [4];
   logic              ovf_acc_q, ovf_q, done_q, busy_q;
   logic [data_w-1:0] sum_d;
   logic              step_ovf_d;

   serial_mult_acc #(.data_w(data_w)) u_mac (
      .a_i  (a_q[A_SCHED[k_q]]),
      .b_i  (b_q[B_SCHED[k_q]]),
      .acc_i(acc_q[ACC_SCHED[k_q]]),
      .sum_o(sum_d),
      .ovf_o(step_ovf_d)
   );

   // sequencer: latch operands on start, accumulate one scheduled product per MUL cycle, publish on step 7
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         k_q       <= '0;
         ovf_acc_q <= 1'b0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            a_q[i]   <= '0;
            b_q[i]   <= '0;
            acc_q[i] <= '0;
            c_q[i]   <= '0;
         end
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: if (start_mac) begin
               a_q       <= '{a_11, a_12, a_21, a_22};
               b_q       <= '{b_11, b_12, b_21, b_22};
               acc_q     <= '{default: '0};
               ovf_acc_q <= 1'b0;
               k_q       <= '0;
               done_q    <= 1'b0;
               busy_q    <= 1'b1;
               state_q   <= ST_MUL;
            end
            ST_MUL: begin
               acc_q[ACC_SCHED[k_q]] <= sum_d;
               ovf_acc_q             <= ovf_acc_q | step_ovf_d;
               k_q                   <= k_q + 3'd1;
               if (k_q == 3'(STEPS - 1)) begin
                  c_q     <= '{acc_q[0], acc_q[1], acc_q[2], sum_d};
                  ovf_q   <= ovf_acc_q | step_ovf_d;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_DONE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign c_11     = c_q[0];
   assign c_12     = c_q[1];
   assign c_21     = c_q[2];
   assign c_22     = c_q[3];
   assign done_mac = done_q;
   assign busy     = busy_q;
   assign ovf      = ovf_q;
endmodule

// File: tb/tb_block_mac_2x2.sv
// tb_block_mac_2x2: directed self-checking bench for the serial 2x2 block multiplier
module tb_block_mac_2x2;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start_mac = 1'b0;
   logic [7:0] a_11, a_12, a_21, a_22, b_11, b_12, b_21, b_22;
   logic [7:0] c_11, c_12, c_21, c_22;
   logic       done_mac, busy, ovf;
   int         checks = 0;
   int         failures = 0;
   int         n;

   localparam logic [31:0] A1 = 32'h01020304;
   localparam logic [31:0] B1 = 32'h05060708;
   localparam logic [31:0] C1 = 32'h13162B32;
   localparam logic [31:0] ONES = 32'hFFFFFFFF;
   localparam logic [31:0] AID = 32'h01000001;
   localparam logic [31:0] B2 = 32'h09080706;

   block_mac_2x2 #(.data_w(8)) dut (
      .clk(clk), .rst(rst), .start_mac(start_mac),
      .a_11(a_11), .a_12(a_12), .a_21(a_21), .a_22(a_22),
      .b_11(b_11), .b_12(b_12), .b_21(b_21), .b_22(b_22),
      .c_11(c_11), .c_12(c_12), .c_21(c_21), .c_22(c_22),
      .done_mac(done_mac), .busy(busy), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic [31:0] a, input logic [31:0] b);
      {a_11, a_12, a_21, a_22} = a;
      {b_11, b_12, b_21, b_22} = b;
   endtask

   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      drive(a, b);
      start_mac = 1'b1;
      @(negedge clk);
      start_mac = 1'b0;
   endtask

   task automatic wait_done(output int cnt);
      cnt = 0;
      while (done_mac !== 1'b1 && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
   endtask

   task automatic test_reset;
      #2 rst = 1'b1;
      #2;
      checks++;
      if ({c_11, c_12, c_21, c_22, done_mac, busy, ovf} !== 35'd0) begin
         failures++;
         $display("FAIL reset_outputs got c=%h done=%b busy=%b ovf=%b want all zero", {c_11, c_12, c_21, c_22}, done_mac, busy, ovf);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic;
      start_op(A1, B1);
      wait_done(n);
      checks++;
      if (n !== 8) begin failures++; $display("FAIL basic_latency got %0d want 8", n); end
      checks++;
      if ({c_11, c_12, c_21, c_22} !== C1) begin failures++; $display("FAIL basic_result got %h want %h", {c_11, c_12, c_21, c_22}, C1); end
      checks++;
      if ({ovf, busy} !== 2'b00) begin failures++; $display("FAIL basic_flags got ovf=%b busy=%b want 0 0", ovf, busy); end
      repeat (3) @(negedge clk);
      checks++;
      if ({done_mac, c_11, c_12, c_21, c_22} !== {1'b1, C1}) begin
         failures++;
         $display("FAIL basic_hold got done=%b c=%h want 1 %h", done_mac, {c_11, c_12, c_21, c_22}, C1);
      end
   endtask

   task automatic test_overflow;
      start_op(ONES, ONES);
      wait_done(n);
      checks++;
      if ({c_11, c_12, c_21, c_22, ovf} !== {32'h02020202, 1'b1}) begin
         failures++;
         $display("FAIL ovf_result got c=%h ovf=%b want 02020202 1", {c_11, c_12, c_21, c_22}, ovf);
      end
      start_op(AID, B2);
      checks++;
      if ({c_11, c_12, c_21, c_22, ovf, done_mac, busy} !== {32'h02020202, 3'b101}) begin
         failures++;
         $display("FAIL ovf_hold_during_op got c=%h ovf=%b done=%b busy=%b want 02020202 1 0 1", {c_11, c_12, c_21, c_22}, ovf, done_mac, busy);
      end
      wait_done(n);
      checks++;
      if ({c_11, c_12, c_21, c_22, ovf} !== {B2, 1'b0}) begin
         failures++;
         $display("FAIL identity_result got c=%h ovf=%b want %h 0", {c_11, c_12, c_21, c_22}, ovf, B2);
      end
   endtask

   task automatic test_operand_change;
      start_op(A1, B1);
      drive(32'hAAAAAAAA, 32'hAAAAAAAA);
      wait_done(n);
      checks++;
      if ({c_11, c_12, c_21, c_22} !== C1) begin failures++; $display("FAIL operand_change got %h want %h", {c_11, c_12, c_21, c_22}, C1); end
   endtask

   task automatic test_back_to_back;
      start_op(A1, B1);
      repeat (2) @(negedge clk);
      drive(ONES, ONES);
      start_mac = 1'b1;
      @(negedge clk);
      start_mac = 1'b0;
      wait_done(n);
      checks++;
      if (n !== 5) begin failures++; $display("FAIL ignored_start_latency got %0d want 5", n); end
      checks++;
      if ({c_11, c_12, c_21, c_22, ovf} !== {C1, 1'b0}) begin
         failures++;
         $display("FAIL ignored_start_result got c=%h ovf=%b want %h 0", {c_11, c_12, c_21, c_22}, ovf, C1);
      end
      drive(AID, B2);
      start_mac = 1'b1;
      @(negedge clk);
      start_mac = 1'b0;
      checks++;
      if ({done_mac, busy, c_11} !== {2'b01, 8'h13}) begin
         failures++;
         $display("FAIL b2b_accept got done=%b busy=%b c_11=%h want 0 1 13", done_mac, busy, c_11);
      end
      wait_done(n);
      checks++;
      if (n !== 8 || {c_11, c_12, c_21, c_22} !== B2) begin
         failures++;
         $display("FAIL b2b_result got lat=%0d c=%h want 8 %h", n, {c_11, c_12, c_21, c_22}, B2);
      end
   endtask

   task automatic test_reset_mid;
      start_op(ONES, ONES);
      wait_done(n);
      start_op(A1, B1);
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({c_11, c_12, c_21, c_22, done_mac, busy, ovf} !== 35'd0) begin
         failures++;
         $display("FAIL reset_mid got c=%h done=%b busy=%b ovf=%b want all zero", {c_11, c_12, c_21, c_22}, done_mac, busy, ovf);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if ({done_mac, busy} !== 2'b00) begin failures++; $display("FAIL reset_discard got done=%b busy=%b want 0 0", done_mac, busy); end
      start_op(A1, B1);
      wait_done(n);
      checks++;
      if (n !== 8 || {c_11, c_12, c_21, c_22, ovf} !== {C1, 1'b0}) begin
         failures++;
         $display("FAIL reset_recover got lat=%0d c=%h ovf=%b want 8 %h 0", n, {c_11, c_12, c_21, c_22}, ovf, C1);
      end
   endtask

   initial begin
      drive(32'd0, 32'd0);
      test_reset;
      test_basic;
      test_overflow;
      test_operand_change;
      test_back_to_back;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
